// File: rtl/hicore_arb_pkg.sv
`default_nettype none
//============================================================================
// Module   : hicore_arb_pkg
// Desc     : Shared types and constants for the memory-port arbiter.
// Revision : 1.0 - initial release
//============================================================================
package hicore_arb_pkg;

    localparam logic SRC_IFU = 1'b0;
    localparam logic SRC_LSU = 1'b1;

    localparam int DEF_CW = 65;
    localparam int DEF_RW = 32;

    // One slot per outstanding command: who issued it, and whether its
    // response has been cancelled by a flush.
    typedef struct packed {
        logic src;
        logic cancel;
    } arb_entry_t;

endpackage
`default_nettype wire

// File: rtl/hicore_arb_order_fifo.sv
`default_nettype none
//============================================================================
// Module   : hicore_arb_order_fifo
// Desc     : In-order source-tracking FIFO with flush-cancel-all.
// Revision : 1.0 - initial release
//============================================================================
module hicore_arb_order_fifo
    import hicore_arb_pkg::*;
#(
    parameter int OST    = 4,
    parameter int LOGOST = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       push_src,
    input  logic       pop,
    input  logic       flush,
    output logic       full,
    output logic       empty,
    output arb_entry_t head
);

    logic [LOGOST:0]   r_wr_ptr;
    logic [LOGOST:0]   r_rd_ptr;
    arb_entry_t        r_mem [OST];
    logic [LOGOST-1:0] w_wr_idx;
    logic [LOGOST-1:0] w_rd_idx;

    assign w_wr_idx = r_wr_ptr[LOGOST-1:0];
    assign w_rd_idx = r_rd_ptr[LOGOST-1:0];

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[LOGOST] != r_rd_ptr[LOGOST]) &&
                   (w_wr_idx == w_rd_idx);
    assign head  = r_mem[w_rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + (LOGOST+1)'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + (LOGOST+1)'(1);
            end
        end
    end

    // Flush marks every slot cancelled; free slots are harmless since a push
    // rewrites them, and a slot pushed on the flush edge is born cancelled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OST; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < OST; i++) begin
                if (push && (w_wr_idx == LOGOST'(i))) begin
                    r_mem[i].src    <= push_src;
                    r_mem[i].cancel <= flush;
                end else if (flush) begin
                    r_mem[i].cancel <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hicore_mem_arbiter.sv
`default_nettype none
//============================================================================
// Module   : hicore_mem_arbiter
// Desc     : Two-requester (IFU/LSU) arbiter for one in-order memory port.
//            Build option HICORE_ARB_FIXED_PRIO_EN: fixed LSU-over-IFU priority.
// Revision : 1.0 - initial release
//============================================================================
module hicore_mem_arbiter
    import hicore_arb_pkg::*;
#(
    parameter int CW     = DEF_CW,
    parameter int RW     = DEF_RW,
    parameter int OST    = 4,
    parameter int LOGOST = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,

    input  logic          m0_cmd_valid,
    output logic          m0_cmd_ready,
    input  logic [CW-1:0] m0_cmd_info,
    output logic          m0_rsp_valid,
    input  logic          m0_rsp_ready,
    output logic [RW-1:0] m0_rsp_data,

    input  logic          m1_cmd_valid,
    output logic          m1_cmd_ready,
    input  logic [CW-1:0] m1_cmd_info,
    output logic          m1_rsp_valid,
    input  logic          m1_rsp_ready,
    output logic [RW-1:0] m1_rsp_data,

    output logic          s_cmd_valid,
    input  logic          s_cmd_ready,
    output logic [CW-1:0] s_cmd_info,
    input  logic          s_rsp_valid,
    output logic          s_rsp_ready,
    input  logic [RW-1:0] s_rsp_data
);

    logic       w_full;
    logic       w_empty;
    arb_entry_t w_head;
    logic       w_req_any;
    logic       w_arb_sel;
    logic       w_sel;
    logic       w_cmd_hs;
    logic       w_rsp_live;
    logic       w_rsp_pop;
    logic       r_lock;
    logic       r_lock_src;

    assign w_req_any = m0_cmd_valid | m1_cmd_valid;

`ifdef HICORE_ARB_FIXED_PRIO_EN
    assign w_arb_sel = m1_cmd_valid ? SRC_LSU : SRC_IFU;
`else
    // Favours the requester that lost the last accepted handshake.
    logic r_rr_ptr;

    assign w_arb_sel = (m0_cmd_valid & m1_cmd_valid) ? r_rr_ptr :
                       (m1_cmd_valid ? SRC_LSU : SRC_IFU);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= SRC_IFU;
        end else if (w_cmd_hs) begin
            r_rr_ptr <= ~w_sel;
        end
    end
`endif

    // A stalled command keeps its grant so s_cmd_info is stable until taken.
    assign w_sel       = r_lock ? r_lock_src : w_arb_sel;
    assign s_cmd_valid = w_req_any & ~w_full;
    assign s_cmd_info  = (w_sel == SRC_LSU) ? m1_cmd_info : m0_cmd_info;
    assign w_cmd_hs    = s_cmd_valid & s_cmd_ready;

    assign m0_cmd_ready = w_req_any & (w_sel == SRC_IFU) & s_cmd_ready & ~w_full;
    assign m1_cmd_ready = w_req_any & (w_sel == SRC_LSU) & s_cmd_ready & ~w_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock     <= 1'b0;
            r_lock_src <= SRC_IFU;
        end else begin
            r_lock     <= s_cmd_valid & ~s_cmd_ready;
            r_lock_src <= w_sel;
        end
    end

    // Cancelled or flushed responses are swallowed without involving either
    // requester; a response with nothing outstanding is never accepted.
    assign w_rsp_live   = s_rsp_valid & ~w_empty & ~w_head.cancel & ~flush;
    assign m0_rsp_valid = w_rsp_live & (w_head.src == SRC_IFU);
    assign m1_rsp_valid = w_rsp_live & (w_head.src == SRC_LSU);
    assign m0_rsp_data  = s_rsp_data;
    assign m1_rsp_data  = s_rsp_data;

    assign s_rsp_ready = ~w_empty & (w_head.cancel | flush |
                         ((w_head.src == SRC_LSU) ? m1_rsp_ready : m0_rsp_ready));
    assign w_rsp_pop   = s_rsp_valid & s_rsp_ready;

    hicore_arb_order_fifo #(
        .OST    (OST),
        .LOGOST (LOGOST)
    ) u_order_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_cmd_hs),
        .push_src (w_sel),
        .pop      (w_rsp_pop),
        .flush    (flush),
        .full     (w_full),
        .empty    (w_empty),
        .head     (w_head)
    );

endmodule
`default_nettype wire

// File: tb/tb_hicore_mem_arbiter.sv
`default_nettype none
//============================================================================
// Module   : tb_hicore_mem_arbiter
// Desc     : Directed self-checking bench for hicore_mem_arbiter.
// Revision : 1.0 - initial release
//============================================================================
module tb_hicore_mem_arbiter;

    localparam int CW = 65;
    localparam int RW = 32;
    localparam logic [CW-1:0] c_info0 = 65'h0_0000_1000_0000_00A0;
    localparam logic [CW-1:0] c_info1 = 65'h1_0000_2000_0000_00B1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          m0_cmd_valid, m0_cmd_ready, m0_rsp_valid, m0_rsp_ready;
    logic [CW-1:0] m0_cmd_info;
    logic [RW-1:0] m0_rsp_data;
    logic          m1_cmd_valid, m1_cmd_ready, m1_rsp_valid, m1_rsp_ready;
    logic [CW-1:0] m1_cmd_info;
    logic [RW-1:0] m1_rsp_data;
    logic          s_cmd_valid, s_cmd_ready, s_rsp_valid, s_rsp_ready;
    logic [CW-1:0] s_cmd_info;
    logic [RW-1:0] s_rsp_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hicore_mem_arbiter #(.CW(CW), .RW(RW), .OST(4), .LOGOST(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .m0_cmd_valid (m0_cmd_valid),
        .m0_cmd_ready (m0_cmd_ready),
        .m0_cmd_info  (m0_cmd_info),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rsp_ready (m0_rsp_ready),
        .m0_rsp_data  (m0_rsp_data),
        .m1_cmd_valid (m1_cmd_valid),
        .m1_cmd_ready (m1_cmd_ready),
        .m1_cmd_info  (m1_cmd_info),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rsp_ready (m1_rsp_ready),
        .m1_rsp_data  (m1_rsp_data),
        .s_cmd_valid  (s_cmd_valid),
        .s_cmd_ready  (s_cmd_ready),
        .s_cmd_info   (s_cmd_info),
        .s_rsp_valid  (s_rsp_valid),
        .s_rsp_ready  (s_rsp_ready),
        .s_rsp_data   (s_rsp_data)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One response the head requester must receive.
    task automatic rsp_expect(input logic src, input logic [RW-1:0] data);
        s_rsp_valid  = 1'b1;
        s_rsp_data   = data;
        m0_rsp_ready = 1'b1;
        m1_rsp_ready = 1'b1;
        #1;
        chk("rsp_m0_valid", m0_rsp_valid, !src);
        chk("rsp_m1_valid", m1_rsp_valid, src);
        chk("rsp_ready", s_rsp_ready, 1'b1);
        chk("rsp_data", src ? m1_rsp_data : m0_rsp_data, data);
        step();
        s_rsp_valid = 1'b0;
    endtask

    // One cancelled response: swallowed even with both requesters stalled.
    task automatic rsp_drop(input logic [RW-1:0] data);
        s_rsp_valid  = 1'b1;
        s_rsp_data   = data;
        m0_rsp_ready = 1'b0;
        m1_rsp_ready = 1'b0;
        #1;
        chk("drop_ready", s_rsp_ready, 1'b1);
        chk("drop_m0_valid", m0_rsp_valid, 1'b0);
        chk("drop_m1_valid", m1_rsp_valid, 1'b0);
        step();
        s_rsp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        m0_cmd_valid = 1'b0; m1_cmd_valid = 1'b0;
        m0_cmd_info = c_info0; m1_cmd_info = c_info1;
        m0_rsp_ready = 1'b0; m1_rsp_ready = 1'b0;
        s_cmd_ready = 1'b0; s_rsp_valid = 1'b0; s_rsp_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m0_cmd_ready", m0_cmd_ready, 1'b0);
        chk("rst_m1_cmd_ready", m1_cmd_ready, 1'b0);
        chk("rst_s_cmd_valid", s_cmd_valid, 1'b0);
        chk("rst_m0_rsp_valid", m0_rsp_valid, 1'b0);
        chk("rst_m1_rsp_valid", m1_rsp_valid, 1'b0);
        chk("rst_s_rsp_ready", s_rsp_ready, 1'b0);
        s_cmd_ready = 1'b1;
        #1;
        chk("idle_m0_cmd_ready", m0_cmd_ready, 1'b0);
        chk("idle_s_cmd_valid", s_cmd_valid, 1'b0);
        rst = 1'b0;
        step();

`ifdef HICORE_ARB_FIXED_PRIO_EN
        m0_cmd_valid = 1'b1; m1_cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("fp_m1_ready", m1_cmd_ready, 1'b1);
            chk("fp_m0_ready", m0_cmd_ready, 1'b0);
            chk("fp_info", s_cmd_info, c_info1);
            step();
        end
        m1_cmd_valid = 1'b0;
        #1;
        chk("fp_m0_after", m0_cmd_ready, 1'b1);
        step();
        m0_cmd_valid = 1'b0;
`else
        // Both requesting: alternate m0,m1,m0,m1, then stall on a full FIFO.
        m0_cmd_valid = 1'b1; m1_cmd_valid = 1'b1;
        m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_m0_ready", m0_cmd_ready, (k % 2) == 0);
            chk("rr_m1_ready", m1_cmd_ready, (k % 2) == 1);
            chk("rr_info", s_cmd_info, ((k % 2) == 1) ? c_info1 : c_info0);
            step();
        end
        #1;
        chk("full_s_cmd_valid", s_cmd_valid, 1'b0);
        chk("full_m0_ready", m0_cmd_ready, 1'b0);
        chk("full_m1_ready", m1_cmd_ready, 1'b0);
        step();
        s_rsp_valid = 1'b1; s_rsp_data = 32'h11;
        #1;
        chk("pop1_m0_valid", m0_rsp_valid, 1'b1);
        chk("pop1_m1_valid", m1_rsp_valid, 1'b0);
        chk("pop1_data", m0_rsp_data, 32'h11);
        chk("no_bypass_m0_ready", m0_cmd_ready, 1'b0);
        step();
        s_rsp_valid = 1'b0;
        #1;
        chk("refill_m0_ready", m0_cmd_ready, 1'b1);
        chk("refill_m1_ready", m1_cmd_ready, 1'b0);
        step();
        m0_cmd_valid = 1'b0; m1_cmd_valid = 1'b0;

        // FIFO now m1,m0,m1,m0; hold the m1 head back for four cycles.
        m1_rsp_ready = 1'b0; s_rsp_valid = 1'b1; s_rsp_data = 32'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_m1_valid", m1_rsp_valid, 1'b1);
            chk("bp_s_rsp_ready", s_rsp_ready, 1'b0);
            step();
        end
        rsp_expect(1'b1, 32'h22);
        rsp_expect(1'b0, 32'h33);
        rsp_expect(1'b1, 32'h44);
        rsp_expect(1'b0, 32'h55);
        s_rsp_valid = 1'b1;
        #1;
        chk("spur_ready", s_rsp_ready, 1'b0);
        chk("spur_m0_valid", m0_rsp_valid, 1'b0);
        chk("spur_m1_valid", m1_rsp_valid, 1'b0);
        s_rsp_valid = 1'b0;

        // Issue m0,m1,m0 singly and route responses back in order.
        m0_cmd_valid = 1'b1; #1; chk("seq_m0a", m0_cmd_ready, 1'b1); step();
        m0_cmd_valid = 1'b0; m1_cmd_valid = 1'b1;
        #1; chk("seq_m1", m1_cmd_ready, 1'b1); step();
        m1_cmd_valid = 1'b0; m0_cmd_valid = 1'b1;
        #1; chk("seq_m0b", m0_cmd_ready, 1'b1); step();
        m0_cmd_valid = 1'b0;
        rsp_expect(1'b0, 32'h11);
        rsp_expect(1'b1, 32'h22);
        rsp_expect(1'b0, 32'h33);

        // One m1 command leaves the pointer favouring m0 before the lock test.
        m1_cmd_valid = 1'b1; #1; chk("pre_lock_m1", m1_cmd_ready, 1'b1); step();
        s_cmd_ready = 1'b0;
        #1;
        chk("lock_s_cmd_valid", s_cmd_valid, 1'b1);
        chk("lock_info_c1", s_cmd_info, c_info1);
        step();
        m0_cmd_valid = 1'b1;
        #1;
        chk("lock_info_c2", s_cmd_info, c_info1);
        chk("lock_m0_ready_c2", m0_cmd_ready, 1'b0);
        step();
        #1;
        chk("lock_info_c3", s_cmd_info, c_info1);
        step();
        s_cmd_ready = 1'b1;
        #1;
        chk("lock_m1_hs", m1_cmd_ready, 1'b1);
        chk("lock_m0_wait", m0_cmd_ready, 1'b0);
        step();
        #1;
        chk("lock_m0_next", m0_cmd_ready, 1'b1);
        chk("lock_m1_next", m1_cmd_ready, 1'b0);
        step();
        m0_cmd_valid = 1'b0; m1_cmd_valid = 1'b0;

        // Three outstanding (m1,m1,m0) cancelled by flush; new m1 survives.
        flush = 1'b1; step(); flush = 1'b0;
        m1_cmd_valid = 1'b1; #1; chk("post_flush_m1", m1_cmd_ready, 1'b1); step();
        m1_cmd_valid = 1'b0;
        rsp_drop(32'hA);
        rsp_drop(32'hB);
        rsp_drop(32'hC);
        rsp_expect(1'b1, 32'hD);

        // Flush consumes the in-flight response and cancels a same-edge push.
        m0_cmd_valid = 1'b1; #1; chk("fe_m0", m0_cmd_ready, 1'b1); step();
        m0_cmd_valid = 1'b0;
        flush = 1'b1; m1_cmd_valid = 1'b1;
        s_rsp_valid = 1'b1; s_rsp_data = 32'h77;
        m0_rsp_ready = 1'b0; m1_rsp_ready = 1'b0;
        #1;
        chk("fe_s_rsp_ready", s_rsp_ready, 1'b1);
        chk("fe_m0_valid", m0_rsp_valid, 1'b0);
        chk("fe_m1_cmd_ready", m1_cmd_ready, 1'b1);
        step();
        flush = 1'b0; m1_cmd_valid = 1'b0; s_rsp_valid = 1'b0;
        rsp_drop(32'h88);
        s_rsp_valid = 1'b1;
        #1;
        chk("fe_empty_ready", s_rsp_ready, 1'b0);
        s_rsp_valid = 1'b0;

        // Reset mid-transfer: FIFO and RR pointer return to their reset state.
        m0_cmd_valid = 1'b1; #1; chk("mid_m0", m0_cmd_ready, 1'b1); step();
        m0_cmd_valid = 1'b0;
        s_rsp_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_rst_rsp_ready", s_rsp_ready, 1'b0);
        chk("mid_rst_m0_valid", m0_rsp_valid, 1'b0);
        step();
        rst = 1'b0; s_rsp_valid = 1'b0;
        m0_cmd_valid = 1'b1; m1_cmd_valid = 1'b1;
        #1;
        chk("post_rst_m0_ready", m0_cmd_ready, 1'b1);
        chk("post_rst_m1_ready", m1_cmd_ready, 1'b0);
        step();
        m0_cmd_valid = 1'b0; m1_cmd_valid = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hicore_mem_arbiter.md
Name: hicore_mem_arbiter

Overview:
- Shares one memory command/response port between two requesters: the instruction fetch unit (m0) and the load/store queue drain (m1).
- Arbitrates commands and records the source of every accepted command in an in-order tracking FIFO.
- Routes in-order responses back to the requester that issued the command.
- On pipeline flush, drops the responses of commands already outstanding.
- Sits between the IFU/mem queue and the core's external memory interface.

Parameters:
- CW, 65, command info width ({wen, addr[31:0], wdata[31:0]}); passed through opaquely.
- RW, 32, response data width.
- OST, 4, max outstanding commands; power of 2, at least 2.
- LOGOST, 2, log2(OST).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush; cancels all outstanding responses.
- m0_cmd_valid  in  1  IFU command valid.
- m0_cmd_ready  out  1  IFU command accepted.
- m0_cmd_info  in  CW  IFU command.
- m0_rsp_valid  out  1  IFU response valid.
- m0_rsp_ready  in  1  IFU response accept.
- m0_rsp_data  out  RW  IFU response data.
- m1_cmd_valid / m1_cmd_ready / m1_cmd_info / m1_rsp_valid / m1_rsp_ready / m1_rsp_data  same as m0, for the LSU.
- s_cmd_valid  out  1  memory command valid.
- s_cmd_ready  in  1  memory accepts command.
- s_cmd_info  out  CW  granted command.
- s_rsp_valid  in  1  memory response valid; responses arrive in command order.
- s_rsp_ready  out  1  response accepted.
- s_rsp_data  in  RW  memory response data.

Behaviour:
- Reset values: all state clear; tracking FIFO empty; RR pointer = m0 favoured. All *_ready and *_valid outputs are 0 while the FIFO is empty and there are no requests.
- Accept condition: a command may issue only when the FIFO count < OST. No same-cycle bypass from a response pop.
- s_cmd_valid = (m0_cmd_valid | m1_cmd_valid) & ~full.
- Grant:
  - Round-robin; the pointer favours the requester not granted in the last accepted handshake.
  - The grant is held (lock register) while s_cmd_valid & ~s_cmd_ready, so s_cmd_info stays stable until accepted.
  - The lock clears on handshake or on reset.
- Command readies: mX_cmd_ready = grantX & s_cmd_ready & ~full. Combinational path s_cmd_ready -> mX_cmd_ready is permitted.
- On command handshake: push {src_id, cancel=0} into the tracking FIFO. The RR pointer updates on the same edge. Zero-cycle command latency (combinational mux).
- Response routing:
  - head = FIFO read entry.
  - m{head.src}_rsp_valid = s_rsp_valid & ~empty & ~head.cancel & ~flush.
  - s_rsp_ready = head.cancel | flush | m{head.src}_rsp_ready.
  - Data is broadcast to both mX_rsp_data; only valid is steered.
  - Pop on s_rsp_valid & s_rsp_ready.
- Spurious response (s_rsp_valid while empty): s_rsp_ready = 0; no state change.
- Flush:
  - Sets the cancel bit of every occupied entry, including one pushed on the same edge.
  - Pointers are unaffected.
  - A response handshaking during a flush cycle is consumed and dropped.
  - Commands presented during flush are still arbitrated; only entries occupied at that edge are cancelled.
- Wrap-around: pointers are LOGOST+1 bits. full = MSBs differ & low bits equal; empty = pointers equal.
- Push and pop in the same cycle: both occur; count is unchanged.
- Reset mid-transfer clears the FIFO and lock. Responses still in flight externally are the memory's responsibility and are discarded after reset.

Optional Feature:
- Macro: HICORE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, m1 (LSU) over m0; the RR pointer is removed; the lock-while-stalled rule still applies.
- Undefined: round-robin as above.

Decomposition:
- Package hicore_arb_pkg:
  - SRC_IFU = 1'b0, SRC_LSU = 1'b1.
  - Tracking entry typedef {src, cancel}.
  - Default CW and RW constants.
- Sub-module hicore_arb_order_fifo: depth-OST pointer FIFO of 2-bit entries with a flush-cancel-all input. Exposes full, empty, and head.

Test Plan:
- Both requesters assert continuously, s_cmd_ready=1, OST=4 -> grants alternate m0,m1,m0,m1; fifth command stalls with m*_cmd_ready=0 until the first response pops.
- m1 requests with s_cmd_ready=0 for 3 cycles while m0 rises in cycle 2 -> grant stays m1 and s_cmd_info is constant until handshake; m0 is granted next.
- Issue m0,m1,m0; return data 0x11,0x22,0x33 -> m0 gets 0x11, m1 gets 0x22, m0 gets 0x33, in order.
- Two outstanding, pulse flush, then a new m1 command; return 0xA,0xB,0xC -> 0xA and 0xB dropped with no mX_rsp_valid; m1 receives 0xC.
- m0_rsp_ready=0 for 4 cycles with s_rsp_valid=1 -> s_rsp_ready=0 and FIFO head held; pop on the first ready cycle.
- With HICORE_ARB_FIXED_PRIO_EN, both requesting for 3 accepts -> m1 granted all 3; m0 starved until m1 deasserts.
